// File: rtl/msx_slot_map_loader.sv
// msx_slot_map_loader: expands the machine-configuration record list into the
// 64-entry {slot, sub_slot, page} block table plus per-slot type/expander flags.
module msx_slot_map_loader (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rec_valid,
  output logic        rec_ready,
  input  logic [4:0]  rec_typ,
  input  logic [3:0]  rec_reference,
  input  logic [7:0]  rec_block_count,
  input  logic [1:0]  rec_slot,
  input  logic [1:0]  rec_sub_slot,
  input  logic [1:0]  rec_start_block,
  input  logic        rec_last,
  output logic        tbl_we,
  output logic [5:0]  tbl_addr,
  output logic [3:0]  tbl_typ,
  output logic [3:0]  tbl_block_id,
  output logic [1:0]  tbl_offset,
  output logic        tbl_init,
  output logic [15:0] slot_typ,
  output logic [3:0]  slot_expanded,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CFG_W  = 5;
  localparam int unsigned TYP_W  = 4;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned CLR_W  = 7;
  localparam int unsigned PAGE_W = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NSLOT  = 4;

  // Configuration record types
  localparam logic [CFG_W-1:0] CFG_RAM        = CFG_W'(1);
  localparam logic [CFG_W-1:0] CFG_RAM_MAPPER = CFG_W'(2);
  localparam logic [CFG_W-1:0] CFG_BIOS       = CFG_W'(3);
  localparam logic [CFG_W-1:0] CFG_FDC        = CFG_W'(4);
  localparam logic [CFG_W-1:0] CFG_CART_A     = CFG_W'(5);
  localparam logic [CFG_W-1:0] CFG_CART_B     = CFG_W'(6);

  // Slot table types
  localparam logic [TYP_W-1:0] SLOT_EMPTY  = TYP_W'(0);
  localparam logic [TYP_W-1:0] SLOT_RAM    = TYP_W'(1);
  localparam logic [TYP_W-1:0] SLOT_ROM    = TYP_W'(2);
  localparam logic [TYP_W-1:0] SLOT_MAPPER = TYP_W'(4);
  localparam logic [TYP_W-1:0] SLOT_CART_A = TYP_W'(5);
  localparam logic [TYP_W-1:0] SLOT_CART_B = TYP_W'(6);
  localparam logic [TYP_W-1:0] SLOT_FDC    = TYP_W'(7);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT,
    ST_FILL,
    ST_DONE
  } state_e;

  // Record held while its pages are being written
  typedef struct packed {
    logic [1:0]        slot;
    logic [1:0]        sub_slot;
    logic [1:0]        start;
    logic [ID_W-1:0]   block_id;
    logic [TYP_W-1:0]  typ;
    logic [PAGE_W-1:0] n;
    logic              last;
  } rec_t;

  state_e                  state_q, state_d;
  logic [CLR_W-1:0]        clr_cnt_q, clr_cnt_d;
  logic [PAGE_W-1:0]       page_q, page_d;
  rec_t                    rec_q, rec_d;

  logic                    tbl_we_q, tbl_we_d;
  logic [ADDR_W-1:0]       tbl_addr_q, tbl_addr_d;
  logic [TYP_W-1:0]        tbl_typ_q, tbl_typ_d;
  logic [ID_W-1:0]         tbl_block_id_q, tbl_block_id_d;
  logic [1:0]              tbl_offset_q, tbl_offset_d;
  logic                    tbl_init_q, tbl_init_d;
  logic [NSLOT*TYP_W-1:0]  slot_typ_q, slot_typ_d;
  logic [NSLOT-1:0]        slot_expanded_q, slot_expanded_d;
  logic                    rec_ready_q, rec_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    acc_mapped;
  logic [TYP_W-1:0]        acc_typ;
  logic [CNT_W-1:0]        acc_room;
  logic [PAGE_W-1:0]       acc_n;
  logic [1:0]              fill_page;

  // Decode the incoming record: slot type and page count clipped to the slot
  always_comb begin
    acc_mapped = 1'b1;
    acc_typ    = SLOT_EMPTY;
    case (rec_typ)
      CFG_RAM:        acc_typ = SLOT_RAM;
      CFG_RAM_MAPPER: acc_typ = SLOT_MAPPER;
      CFG_BIOS:       acc_typ = SLOT_ROM;
      CFG_FDC:        acc_typ = SLOT_FDC;
      CFG_CART_A:     acc_typ = SLOT_CART_A;
      CFG_CART_B:     acc_typ = SLOT_CART_B;
      default:        acc_mapped = 1'b0;
    endcase
    acc_room = CNT_W'(PAGE_W'(4) - PAGE_W'(rec_start_block));
    acc_n    = PAGE_W'((rec_block_count < acc_room) ? rec_block_count : acc_room);
  end

  assign fill_page = rec_q.start + page_q[1:0];

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    clr_cnt_d       = clr_cnt_q;
    page_d          = page_q;
    rec_d           = rec_q;
    tbl_we_d        = 1'b0;
    tbl_addr_d      = tbl_addr_q;
    tbl_typ_d       = tbl_typ_q;
    tbl_block_id_d  = tbl_block_id_q;
    tbl_offset_d    = tbl_offset_q;
    tbl_init_d      = tbl_init_q;
    slot_typ_d      = slot_typ_q;
    slot_expanded_d = slot_expanded_q;
    rec_ready_d     = 1'b0;
    busy_d          = busy_q;
    done_d          = done_q;

    if (start) begin
      // Abort whatever is running and write entry 0 of the clear sweep now
      state_d         = ST_CLEAR;
      clr_cnt_d       = CLR_W'(1);
      tbl_we_d        = 1'b1;
      tbl_addr_d      = '0;
      tbl_typ_d       = SLOT_EMPTY;
      tbl_block_id_d  = '0;
      tbl_offset_d    = '0;
      tbl_init_d      = 1'b0;
      slot_typ_d      = '0;
      slot_expanded_d = '0;
      busy_d          = 1'b1;
      done_d          = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
          done_d = 1'b0;
        end
        ST_CLEAR: begin
          if (clr_cnt_q[CLR_W-1]) begin
            state_d     = ST_WAIT;
            rec_ready_d = 1'b1;
          end else begin
            tbl_we_d       = 1'b1;
            tbl_addr_d     = clr_cnt_q[ADDR_W-1:0];
            tbl_typ_d      = SLOT_EMPTY;
            tbl_block_id_d = '0;
            tbl_offset_d   = '0;
            tbl_init_d     = 1'b0;
            clr_cnt_d      = clr_cnt_q + CLR_W'(1);
          end
        end
        ST_WAIT: begin
          rec_ready_d = 1'b1;
          if (rec_valid && rec_ready_q) begin
            rec_ready_d       = 1'b0;
            state_d           = ST_FILL;
            rec_d.slot        = rec_slot;
            rec_d.sub_slot    = rec_sub_slot;
            rec_d.start       = rec_start_block;
            rec_d.block_id    = rec_reference;
            rec_d.typ         = acc_typ;
            rec_d.last        = rec_last;
            page_d            = '0;
            rec_d.n           = '0;
            // Page 0 goes out on the accept edge; unmapped records idle one cycle in FILL
            if (acc_mapped && (acc_n != '0)) begin
              rec_d.n         = acc_n;
              page_d          = PAGE_W'(1);
              tbl_we_d        = 1'b1;
              tbl_addr_d      = {rec_slot, rec_sub_slot, rec_start_block};
              tbl_typ_d       = acc_typ;
              tbl_block_id_d  = rec_reference;
              tbl_offset_d    = '0;
              tbl_init_d      = 1'b1;
              slot_typ_d[{rec_slot, 2'b00} +: TYP_W] = acc_typ;
              if (rec_sub_slot != '0) begin
                slot_expanded_d[rec_slot] = 1'b1;
              end
            end
          end
        end
        ST_FILL: begin
          if (page_q == rec_q.n) begin
            if (rec_q.last) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d     = ST_WAIT;
              rec_ready_d = 1'b1;
            end
          end else begin
            tbl_we_d       = 1'b1;
            tbl_addr_d     = {rec_q.slot, rec_q.sub_slot, fill_page};
            tbl_typ_d      = rec_q.typ;
            tbl_block_id_d = rec_q.block_id;
            tbl_offset_d   = page_q[1:0];
            tbl_init_d     = 1'b0;
            page_d         = page_q + PAGE_W'(1);
          end
        end
        ST_DONE: begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      clr_cnt_q       <= '0;
      page_q          <= '0;
      rec_q           <= '0;
      tbl_we_q        <= 1'b0;
      tbl_addr_q      <= '0;
      tbl_typ_q       <= '0;
      tbl_block_id_q  <= '0;
      tbl_offset_q    <= '0;
      tbl_init_q      <= 1'b0;
      slot_typ_q      <= '0;
      slot_expanded_q <= '0;
      rec_ready_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      page_q          <= page_d;
      rec_q           <= rec_d;
      tbl_we_q        <= tbl_we_d;
      tbl_addr_q      <= tbl_addr_d;
      tbl_typ_q       <= tbl_typ_d;
      tbl_block_id_q  <= tbl_block_id_d;
      tbl_offset_q    <= tbl_offset_d;
      tbl_init_q      <= tbl_init_d;
      slot_typ_q      <= slot_typ_d;
      slot_expanded_q <= slot_expanded_d;
      rec_ready_q     <= rec_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign tbl_we        = tbl_we_q;
  assign tbl_addr      = tbl_addr_q;
  assign tbl_typ       = tbl_typ_q;
  assign tbl_block_id  = tbl_block_id_q;
  assign tbl_offset    = tbl_offset_q;
  assign tbl_init      = tbl_init_q;
  assign slot_typ      = slot_typ_q;
  assign slot_expanded = slot_expanded_q;
  assign rec_ready     = rec_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_msx_slot_map_loader.sv
// Testbench for msx_slot_map_loader: directed scenarios plus randomized record
// lists checked against a table-level reference model.
module tb_msx_slot_map_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        rec_valid = 1'b0;
  logic        rec_ready;
  logic [4:0]  rec_typ = '0;
  logic [3:0]  rec_reference = '0;
  logic [7:0]  rec_block_count = '0;
  logic [1:0]  rec_slot = '0;
  logic [1:0]  rec_sub_slot = '0;
  logic [1:0]  rec_start_block = '0;
  logic        rec_last = 1'b0;
  logic        tbl_we;
  logic [5:0]  tbl_addr;
  logic [3:0]  tbl_typ;
  logic [3:0]  tbl_block_id;
  logic [1:0]  tbl_offset;
  logic        tbl_init;
  logic [15:0] slot_typ;
  logic [3:0]  slot_expanded;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  // Outputs seen on the 6 cycles following an accepted record
  logic       obs_we[6];
  logic [5:0] obs_addr[6];
  logic [3:0] obs_typ[6];
  logic [3:0] obs_id[6];
  logic [1:0] obs_off[6];
  logic       obs_init[6];
  logic       obs_ready[6];
  logic       obs_busy[6];
  logic       obs_done[6];

  always #5 clk_sys = ~clk_sys;

  msx_slot_map_loader dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .start           (start),
    .rec_valid       (rec_valid),
    .rec_ready       (rec_ready),
    .rec_typ         (rec_typ),
    .rec_reference   (rec_reference),
    .rec_block_count (rec_block_count),
    .rec_slot        (rec_slot),
    .rec_sub_slot    (rec_sub_slot),
    .rec_start_block (rec_start_block),
    .rec_last        (rec_last),
    .tbl_we          (tbl_we),
    .tbl_addr        (tbl_addr),
    .tbl_typ         (tbl_typ),
    .tbl_block_id    (tbl_block_id),
    .tbl_offset      (tbl_offset),
    .tbl_init        (tbl_init),
    .slot_typ        (slot_typ),
    .slot_expanded   (slot_expanded),
    .busy            (busy),
    .done            (done)
  );

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Pulse start and sit through the 64-cycle clear sweep
  task automatic start_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (64) step();
  endtask

  // Offer one record when ready, then record outputs for 6 cycles
  task automatic send_capture(input logic [4:0] typ, input logic [3:0] rf,
                              input logic [7:0] cnt, input logic [1:0] sl,
                              input logic [1:0] sb, input logic [1:0] st,
                              input logic last, output bit ok);
    int w = 0;
    while (rec_ready !== 1'b1 && w < 8) begin
      step();
      w++;
    end
    ok = (rec_ready === 1'b1);
    if (ok) begin
      rec_typ = typ; rec_reference = rf; rec_block_count = cnt;
      rec_slot = sl; rec_sub_slot = sb; rec_start_block = st; rec_last = last;
      rec_valid = 1'b1;
      step();
      rec_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (k > 0) step();
        obs_we[k] = tbl_we; obs_addr[k] = tbl_addr; obs_typ[k] = tbl_typ;
        obs_id[k] = tbl_block_id; obs_off[k] = tbl_offset; obs_init[k] = tbl_init;
        obs_ready[k] = rec_ready; obs_busy[k] = busy; obs_done[k] = done;
      end
    end
  endtask

  // Spec type mapping: returns -1 for types that produce no writes
  function automatic int model_map(input int t);
    case (t)
      1: return 1;
      2: return 4;
      3: return 2;
      4: return 7;
      5: return 5;
      6: return 6;
      default: return -1;
    endcase
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({rec_ready, tbl_we, tbl_addr, tbl_typ, tbl_block_id, tbl_offset, tbl_init,
         slot_typ, slot_expanded, busy, done} !== 40'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {rec_ready, tbl_we, tbl_addr, tbl_typ,
               tbl_block_id, tbl_offset, tbl_init, slot_typ, slot_expanded, busy, done});
    end
    reset_n = 1'b1;
    step();
    checks++;
    if ({rec_ready, tbl_we, busy, done} !== 4'h0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=0000", {rec_ready, tbl_we, busy, done});
    end
  endtask

  task automatic test_clear();
    logic [20:0] got, exp;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      got = {tbl_we, tbl_addr, tbl_typ, tbl_block_id, tbl_offset, tbl_init, rec_ready, busy, done};
      exp = {1'b1, 6'(i - 1), 4'h0, 4'h0, 2'h0, 1'b0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL clear_write cyc%0d got=%h exp=%h", i, got, exp);
      end
      step();
    end
    checks++;
    if ({tbl_we, rec_ready, busy, done, slot_typ, slot_expanded} !== {4'b0110, 16'h0, 4'h0}) begin
      failures++;
      $display("FAIL clear_end got=%h exp=%h", {tbl_we, rec_ready, busy, done, slot_typ, slot_expanded},
               {4'b0110, 16'h0, 4'h0});
    end
  endtask

  task automatic test_bios_mapper();
    bit ok;
    send_capture(5'd3, 4'd3, 8'd2, 2'd0, 2'd0, 2'd0, 1'b0, ok);
    checks++;
    if (!ok || {obs_we[0], obs_addr[0], obs_typ[0], obs_id[0], obs_off[0], obs_init[0]} !== {1'b1, 6'd0, 4'd2, 4'd3, 2'd0, 1'b1}
            || {obs_we[1], obs_addr[1], obs_off[1], obs_init[1]} !== {1'b1, 6'd1, 2'd1, 1'b0}) begin
      failures++;
      $display("FAIL bios_writes got=%h/%h exp=%h/%h", {obs_we[0], obs_addr[0], obs_typ[0], obs_id[0], obs_off[0], obs_init[0]},
               {obs_we[1], obs_addr[1], obs_off[1], obs_init[1]}, {1'b1, 6'd0, 4'd2, 4'd3, 2'd0, 1'b1}, {1'b1, 6'd1, 2'd1, 1'b0});
    end
    checks++;
    if ({obs_we[2], obs_ready[2], obs_busy[2], obs_done[2], slot_typ, slot_expanded} !== {4'b0110, 16'h0002, 4'h0}) begin
      failures++;
      $display("FAIL bios_after got=%h exp=%h", {obs_we[2], obs_ready[2], obs_busy[2], obs_done[2], slot_typ, slot_expanded},
               {4'b0110, 16'h0002, 4'h0});
    end
    send_capture(5'd2, 4'd1, 8'd8, 2'd3, 2'd2, 2'd0, 1'b1, ok);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!ok || {obs_we[k], obs_addr[k], obs_typ[k], obs_id[k], obs_off[k], obs_init[k]}
                 !== {1'b1, 6'(56 + k), 4'd4, 4'd1, 2'(k), (k == 0)}) begin
        failures++;
        $display("FAIL mapper_write k%0d got=%h exp=%h", k, {obs_we[k], obs_addr[k], obs_typ[k], obs_id[k], obs_off[k], obs_init[k]},
                 {1'b1, 6'(56 + k), 4'd4, 4'd1, 2'(k), (k == 0)});
      end
    end
    checks++;
    if ({obs_we[4], obs_ready[4], obs_busy[4], obs_done[4], obs_done[5], slot_typ, slot_expanded}
        !== {5'b00011, 16'h4002, 4'b1000}) begin
      failures++;
      $display("FAIL mapper_done got=%h exp=%h", {obs_we[4], obs_ready[4], obs_busy[4], obs_done[4], obs_done[5], slot_typ, slot_expanded},
               {5'b00011, 16'h4002, 4'b1000});
    end
  endtask

  task automatic test_cart_count0();
    bit ok;
    start_clear();
    send_capture(5'd5, 4'd7, 8'd4, 2'd1, 2'd0, 2'd2, 1'b0, ok);
    checks++;
    if (!ok || {obs_we[0], obs_addr[0], obs_typ[0], obs_id[0], obs_off[0], obs_init[0],
                obs_we[1], obs_addr[1], obs_off[1], obs_init[1], obs_we[2], obs_ready[2]}
               !== {1'b1, 6'd18, 4'd5, 4'd7, 2'd0, 1'b1, 1'b1, 6'd19, 2'd1, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL cart_clip got=%h %h %h", {obs_we[0], obs_addr[0], obs_typ[0], obs_id[0], obs_off[0], obs_init[0]},
               {obs_we[1], obs_addr[1], obs_off[1], obs_init[1]}, {obs_we[2], obs_ready[2]});
    end
    send_capture(5'd1, 4'd2, 8'd0, 2'd2, 2'd1, 2'd1, 1'b0, ok);
    checks++;
    if (!ok || {obs_we[0], obs_ready[0], obs_busy[0], obs_we[1], obs_ready[1], obs_done[1], slot_typ, slot_expanded}
               !== {6'b001010, 16'h0050, 4'h0}) begin
      failures++;
      $display("FAIL count0 got=%h exp=%h", {obs_we[0], obs_ready[0], obs_busy[0], obs_we[1], obs_ready[1], obs_done[1], slot_typ, slot_expanded},
               {6'b001010, 16'h0050, 4'h0});
    end
  endtask

  task automatic test_kbd_last();
    bit ok;
    start_clear();
    send_capture(5'd7, 4'd4, 8'd2, 2'd2, 2'd0, 2'd0, 1'b1, ok);
    checks++;
    if (!ok || {obs_we[0], obs_ready[0], obs_busy[0], obs_done[0]} !== 4'b0010
            || {obs_we[1], obs_ready[1], obs_busy[1], obs_done[1], obs_done[5]} !== 5'b00011) begin
      failures++;
      $display("FAIL kbd_last got=%b/%b exp=0010/00011", {obs_we[0], obs_ready[0], obs_busy[0], obs_done[0]},
               {obs_we[1], obs_ready[1], obs_busy[1], obs_done[1], obs_done[5]});
    end
  endtask

  task automatic test_start_in_fill();
    start_clear();
    rec_typ = 5'd1; rec_reference = 4'd9; rec_block_count = 8'd4; rec_slot = 2'd2;
    rec_sub_slot = 2'd0; rec_start_block = 2'd0; rec_last = 1'b1; rec_valid = 1'b1;
    step();
    rec_valid = 1'b0;
    step();
    checks++;
    if ({tbl_we, tbl_addr, tbl_typ, slot_typ} !== {1'b1, 6'd33, 4'd1, 16'h0100}) begin
      failures++;
      $display("FAIL fill_before_abort got=%h exp=%h", {tbl_we, tbl_addr, tbl_typ, slot_typ}, {1'b1, 6'd33, 4'd1, 16'h0100});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({tbl_we, tbl_addr, tbl_typ, tbl_block_id, tbl_init, slot_typ, busy, done} !== {1'b1, 6'd0, 4'd0, 4'd0, 1'b0, 16'h0, 2'b10}) begin
      failures++;
      $display("FAIL abort_restart got=%h exp=%h", {tbl_we, tbl_addr, tbl_typ, tbl_block_id, tbl_init, slot_typ, busy, done},
               {1'b1, 6'd0, 4'd0, 4'd0, 1'b0, 16'h0, 2'b10});
    end
    for (int i = 1; i < 64; i++) begin
      step();
      checks++;
      if ({tbl_we, tbl_addr, tbl_typ, done} !== {1'b1, 6'(i), 4'd0, 1'b0}) begin
        failures++;
        $display("FAIL abort_clear cyc%0d got=%h exp=%h", i, {tbl_we, tbl_addr, tbl_typ, done}, {1'b1, 6'(i), 4'd0, 1'b0});
      end
    end
    step();
    checks++;
    if ({tbl_we, rec_ready, done} !== 3'b010) begin
      failures++;
      $display("FAIL abort_wait got=%b exp=010", {tbl_we, rec_ready, done});
    end
  endtask

  task automatic test_reset_mid_fill();
    int stray;
    start_clear();
    rec_typ = 5'd3; rec_reference = 4'd5; rec_block_count = 8'd4; rec_slot = 2'd0;
    rec_sub_slot = 2'd1; rec_start_block = 2'd0; rec_last = 1'b0; rec_valid = 1'b1;
    step();
    rec_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rec_ready, tbl_we, tbl_addr, tbl_typ, tbl_block_id, tbl_offset, tbl_init,
         slot_typ, slot_expanded, busy, done} !== 40'h0) begin
      failures++;
      $display("FAIL reset_mid_fill got=%h exp=0", {rec_ready, tbl_we, tbl_addr, tbl_typ,
               tbl_block_id, tbl_offset, tbl_init, slot_typ, slot_expanded, busy, done});
    end
    stray = 0;
    repeat (3) begin
      step();
      if (tbl_we !== 1'b0) stray++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      step();
      if (tbl_we !== 1'b0 || rec_ready !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL reset_no_writes got=%0d exp=0", stray);
    end
    test_clear();
  endtask

  task automatic test_random();
    int m_typ[4];
    bit m_exp[4];
    for (int l = 0; l < 6; l++) begin
      int nrec;
      start_clear();
      for (int s = 0; s < 4; s++) begin m_typ[s] = 0; m_exp[s] = 1'b0; end
      nrec = $urandom_range(1, 6);
      for (int r = 0; r < nrec; r++) begin
        int t, rf, cnt, sl, sb, st, sel, mt, n, len;
        bit last, ok;
        logic [15:0] exp_st;
        logic [3:0] exp_x;
        t = $urandom_range(0, 12);
        if (t == 12) t = $urandom_range(11, 31);
        sel = $urandom_range(0, 3);
        cnt = (sel == 0) ? $urandom_range(0, 4) : (sel == 1) ? $urandom_range(5, 255)
            : (sel == 2) ? 0 : $urandom_range(1, 3);
        rf = $urandom_range(0, 15); sl = $urandom_range(0, 3);
        sb = $urandom_range(0, 3); st = $urandom_range(0, 3);
        last = (r == nrec - 1);
        mt = model_map(t);
        n = (cnt < 4 - st) ? cnt : 4 - st;
        if (mt < 0) n = 0;
        len = (n > 0) ? n : 1;
        send_capture(5'(t), 4'(rf), 8'(cnt), 2'(sl), 2'(sb), 2'(st), last, ok);
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL rand_ready_timeout list%0d rec%0d got=%b exp=1", l, r, rec_ready);
          continue;
        end
        if (n > 0) begin
          m_typ[sl] = mt;
          if (sb != 0) m_exp[sl] = 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
          logic [3:0] ectl, gctl;
          logic [16:0] edat, gdat;
          if (k < len) ectl = {(k < n), 1'b0, 1'b1, 1'b0};
          else if (last) ectl = 4'b0001;
          else ectl = 4'b0110;
          gctl = {obs_we[k], obs_ready[k], obs_busy[k], obs_done[k]};
          checks++;
          if (gctl !== ectl) begin
            failures++;
            $display("FAIL rand_ctl list%0d rec%0d k%0d typ%0d cnt%0d got=%b exp=%b", l, r, k, t, cnt, gctl, ectl);
          end
          if (k < n) begin
            edat = {6'(sl * 16 + sb * 4 + st + k), 4'(mt), 4'(rf), 2'(k), (k == 0)};
            gdat = {obs_addr[k], obs_typ[k], obs_id[k], obs_off[k], obs_init[k]};
            checks++;
            if (gdat !== edat) begin
              failures++;
              $display("FAIL rand_write list%0d rec%0d k%0d got=%h exp=%h", l, r, k, gdat, edat);
            end
          end
        end
        exp_st = {4'(m_typ[3]), 4'(m_typ[2]), 4'(m_typ[1]), 4'(m_typ[0])};
        exp_x = {m_exp[3], m_exp[2], m_exp[1], m_exp[0]};
        checks++;
        if ({slot_typ, slot_expanded} !== {exp_st, exp_x}) begin
          failures++;
          $display("FAIL rand_slot list%0d rec%0d got=%h exp=%h", l, r, {slot_typ, slot_expanded}, {exp_st, exp_x});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_bios_mapper();
    test_cart_count0();
    test_kbd_last();
    test_start_in_fill();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msx_slot_map_loader.md
# msx_slot_map_loader

Consumes the ordered list of machine-configuration records (type, reference, block count, slot, sub-slot, start page) and expands it into the 64-entry slot/sub-slot/page memory-block table plus per-slot type and expander flags used by the MSX memory decoder. Sits between the configuration record source (firmware/DDR3 config reader) and the slot decoder's block table RAM. It is the consumer of the configuration-record stream.

## Interface
- No parameters; table geometry is fixed at 4 slots x 4 sub-slots x 4 pages.
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear table and begin accepting records
- rec_valid  in  1  record present on rec_* inputs
- rec_ready  out  1  loader accepts a record this cycle
- rec_typ  in  5  config type (NONE=0, RAM=1, RAM_MAPPER=2, BIOS=3, FDC=4, CART_A=5, CART_B=6, KBD_LAYOUT=7, ROM_MIRROR=8, IO_MIRROR=9, MIRROR=10)
- rec_reference  in  4  block id of the backing memory region
- rec_block_count  in  8  number of 16 KB pages
- rec_slot  in  2  primary slot
- rec_sub_slot  in  2  sub-slot
- rec_start_block  in  2  first page (0..3)
- rec_last  in  1  this record ends the list
- tbl_we  out  1  table write strobe
- tbl_addr  out  6  {slot, sub_slot, page}
- tbl_typ  out  4  slot type (EMPTY=0, RAM=1, ROM=2, MSX2_RAM=3, MAPPER=4, CART_A=5, CART_B=6, FDC=7)
- tbl_block_id  out  4  block id
- tbl_offset  out  2  page index within the record
- tbl_init  out  1  first page of the record
- slot_typ  out  16  {slot3..slot0} 4-bit types
- slot_expanded  out  4  per-slot expander present
- busy  out  1  CLEAR or load in progress
- done  out  1  list fully applied

## Operation
- States: IDLE, CLEAR, WAIT, FILL, DONE.
- IDLE: rec_ready=0; start -> CLEAR.
- CLEAR: 64 writes, tbl_addr 0..63, tbl_typ=EMPTY, block_id/offset/init=0; slot_typ and slot_expanded cleared on entry; after addr 63 -> WAIT.
- WAIT: rec_ready=1. On rec_valid&rec_ready latch record. Type mapping: RAM->RAM, RAM_MAPPER->MAPPER, BIOS->ROM, FDC->FDC, CART_A->CART_A, CART_B->CART_B; all other types produce no writes.
- Effective count N = min(rec_block_count, 4 - rec_start_block), computed at 8-bit width without wrap. Mapped type and N>0 -> FILL; otherwise rec_last ? DONE : WAIT.
- FILL: page k (0..N-1) written at addr {slot, sub_slot, start+k}, tbl_offset=k[1:0], tbl_init=(k==0), tbl_block_id=reference. On k==0 write: slot_typ[slot] := mapped type (later records overwrite); rec_sub_slot!=0 sets slot_expanded[slot]. After page N-1 -> rec_last ? DONE : WAIT.
- DONE: done=1, busy=0, rec_ready=0; holds until start.
- start in any state (including CLEAR/FILL) aborts and restarts CLEAR at addr 0; pending record is discarded.
- rec_last with unmapped type or N=0 still terminates the list.

## Timing
- Reset: state IDLE; all outputs 0 (tbl_we, rec_ready, busy, done, slot_typ, slot_expanded, tbl_*).
- All outputs registered.
- start at cycle 0 -> first CLEAR write (tbl_we=1, addr 0) at cycle 1; addr 63 at cycle 64; rec_ready=1 from cycle 65.
- Accept at cycle t -> first FILL write at t+1, one write per cycle, rec_ready low from t+1 until cycle after last write.
- Unmapped/N=0 record: rec_ready low for exactly one cycle after accept (or DONE if last).
- done rises the cycle after the last write (or after accepting an unmapped last record).
- busy=1 from cycle after start through the final write.

## Test plan
- Reset mid-FILL -> all outputs 0 next edge, no further tbl_we; start -> 64 EMPTY writes addr 0..63 then rec_ready=1 at cycle 65.
- BIOS rec slot0 sub0 start0 count2 ref3 last=0 -> writes addr 0 (ROM, id3, off0, init1), addr 1 (off1, init0); slot_typ[3:0]=2; slot_expanded=0.
- RAM_MAPPER slot3 sub2 start0 count8 ref1 last=1 -> 4 writes addr 56..59 typ4 off0..3; slot_typ[15:12]=4; slot_expanded[3]=1; done next cycle.
- CART_A slot1 sub0 start2 count4 -> N=2, writes addr 18,19 only; count 0 record -> no writes, rec_ready back after 1 cycle.
- KBD_LAYOUT record with last=1 -> no writes, done=1 two cycles after accept.
- start asserted during FILL -> write sequence restarts at CLEAR addr 0, slot_typ cleared, done stays 0.
